// File: rtl/idecode_pipe.sv
//------------------------------------------------------------------------------
// idecode_pipe : register file with bypass, decode, valid/ready output stage.
// Optional feature macro: SCOREBOARD_EN (pending-register hazard interlock).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module idecode_pipe #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5,
  parameter int LINK_REG  = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rs_data,
  output logic [XLEN-1:0]   out_rt_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_wen,
  output logic              out_link,
  output logic [XLEN-1:0]   out_pc_plus4
);

  logic [XLEN-1:0]   regs [REG_COUNT];
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] rs_idx;
  logic [ADDR_W-1:0] rt_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic [XLEN-1:0]   rs_val;
  logic [XLEN-1:0]   rt_val;
  logic [XLEN-1:0]   dec_imm;
  logic [ADDR_W-1:0] dec_dest;
  logic              dec_wen;
  logic              dec_link;
  logic              accept;

  assign opcode = instruction[31:26];
  assign rs_idx = instruction[21 +: ADDR_W];
  assign rt_idx = instruction[16 +: ADDR_W];
  assign rd_idx = instruction[11 +: ADDR_W];
  assign accept = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Same-cycle writeback wins over the stored value; r0 always reads zero.
  always_comb begin
    rs_val = regs[rs_idx];
    rt_val = regs[rt_idx];
    if (wb_en && (wb_addr == rs_idx)) rs_val = wb_data;
    if (wb_en && (wb_addr == rt_idx)) rt_val = wb_data;
    if (rs_idx == '0) rs_val = '0;
    if (rt_idx == '0) rt_val = '0;
  end

  always_comb begin
    dec_dest = '0;
    dec_wen  = 1'b0;
    dec_link = 1'b0;
    case (opcode)
      6'h0C, 6'h0D, 6'h0E: dec_imm = {{(XLEN-16){1'b0}}, instruction[15:0]};
      6'h0F:               dec_imm = XLEN'({instruction[15:0], 16'h0000});
      default:             dec_imm = {{(XLEN-16){instruction[15]}}, instruction[15:0]};
    endcase
    case (opcode)
      6'h00: begin
        dec_dest = rd_idx;
        dec_wen  = 1'b1;
      end
      6'h03: begin
        dec_dest = ADDR_W'(LINK_REG);
        dec_wen  = 1'b1;
        dec_link = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: begin
        dec_dest = rt_idx;
        dec_wen  = 1'b1;
      end
      default: begin
        dec_dest = '0;
        dec_wen  = 1'b0;
      end
    endcase
    if (dec_dest == '0) dec_wen = 1'b0;
  end

`ifdef SCOREBOARD_EN
  logic [REG_COUNT-1:0] pending;
  logic [REG_COUNT-1:0] pending_next;
  logic                 hazard;

  // A pending source being written back this cycle is covered by the bypass.
  always_comb begin
    hazard = (pending[rs_idx] && !(wb_en && (wb_addr == rs_idx))) ||
             (pending[rt_idx] && !(wb_en && (wb_addr == rt_idx)));
  end

  always_comb begin
    pending_next = pending;
    if (wb_en) pending_next[wb_addr] = 1'b0;
    if (accept && !flush && dec_wen) pending_next[dec_dest] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pending_next;
  end

  assign in_ready = (!out_valid || out_ready) && !hazard;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_rs_data  <= '0;
      out_rt_data  <= '0;
      out_imm      <= '0;
      out_dest     <= '0;
      out_wen      <= 1'b0;
      out_link     <= 1'b0;
      out_pc_plus4 <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_rs_data  <= rs_val;
      out_rt_data  <= rt_val;
      out_imm      <= dec_imm;
      out_dest     <= dec_dest;
      out_wen      <= dec_wen;
      out_link     <= dec_link;
      out_pc_plus4 <= pc_plus4;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/idecode_pipe.md
Name: idecode_pipe

Overview:
Parametrised successor of the single-cycle decode and register-file stage. It holds a REG_COUNT x XLEN register file with r0 hardwired to zero and same-cycle write-to-read bypass. It decodes immediate, destination and link fields, and registers the results into a valid/ready output stage with flush. It sits between instruction fetch and execute in the pipelined core.

Parameters:
XLEN, 32, datapath and register width
REG_COUNT, 32, number of architectural registers (power of two, 2..32)
ADDR_W, 5, register index width, equal to log2(REG_COUNT)
LINK_REG, 31, register index written by jal

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  instruction and pc_plus4 are valid
in_ready  out  1  stage accepts an instruction this cycle
instruction  in  32  MIPS instruction word
pc_plus4  in  XLEN  link address from fetch
wb_en  in  1  writeback strobe
wb_addr  in  ADDR_W  writeback register index
wb_data  in  XLEN  writeback data, already muxed between ALU and memory
flush  in  1  kill the held output and any instruction accepted this cycle
out_valid  out  1  output bundle is valid
out_ready  in  1  execute consumes the bundle
out_rs_data  out  XLEN  operand A
out_rt_data  out  XLEN  operand B
out_imm  out  XLEN  extended immediate
out_dest  out  ADDR_W  destination index
out_wen  out  1  instruction writes a register
out_link  out  1  instruction is jal
out_pc_plus4  out  XLEN  forwarded link address

Behaviour:
- Reset (reset=0, asynchronous): all registers, out_valid and every out_* output go to 0. in_ready is 1 once reset is released.
- Register write, on posedge: if wb_en and wb_addr!=0, then reg[wb_addr] <= wb_data. Writes to r0 are dropped; reading r0 always returns 0.
- Read is combinational on rs = instr[25:21] and rt = instr[20:16], truncated to ADDR_W. Bypass: if wb_en and wb_addr==index and index!=0, the read returns wb_data.
- Immediate:
  - opcode 0x0C, 0x0D, 0x0E (andi/ori/xori): zero-extend.
  - opcode 0x0F (lui): {imm, 16'b0}.
  - otherwise: sign-extend from bit 15.
- Destination and write enable:
  - opcode 0x00: dest = rd, wen = 1.
  - opcode 0x03: dest = LINK_REG, wen = 1, link = 1.
  - opcode 0x08..0x0F or 0x23: dest = rt, wen = 1.
  - all others: wen = 0, dest = 0.
  - wen is forced to 0 when dest==0.
- Handshake:
  - in_ready = !out_valid || out_ready. Without SCOREBOARD_EN this is the only term.
  - Accept = in_valid && in_ready. On accept, all out_* load next edge and out_valid <= 1.
  - If out_ready and no accept, out_valid <= 0.
  - out_* hold stable while out_valid && !out_ready.
- Flush: has priority. out_valid <= 0 next edge and any simultaneous accept is discarded. Register file writes are unaffected.
- Latency: 1 cycle from accept to out_valid. Sustained throughput is 1 instruction per cycle when out_ready=1.

Optional Feature:
SCOREBOARD_EN
- Defined: adds a REG_COUNT-bit pending bitmap, reset to 0.
  - On accept with wen=1, set bit[dest].
  - On wb_en, clear bit[wb_addr]. If set and clear hit the same bit in one cycle, set wins.
  - in_ready additionally requires that rs and rt are not pending, except a pending source that is being written this cycle (bypass covers it).
  - r0 is never pending. Flush clears the bit set by the discarded accept only.
- Undefined: no bitmap. Hazards are the responsibility of downstream forwarding.

Test Plan:
- Reset low mid-stream with out_valid=1 -> out_valid=0 and all out_*=0 immediately. After release, reading r5 returns 0.
- wb_en=1, wb_addr=8, wb_data=0x1234 in the same cycle as accepting add $3,$8,$0 (0x01001820) -> out_rs_data=0x1234, out_dest=3, out_wen=1.
- Accept ori $2,$0,0x8001 -> out_imm=0x00008001. Accept addi $2,$0,0x8001 -> out_imm=0xFFFF8001. Accept lui $2,0x1234 -> out_imm=0x12340000.
- Accept jal with pc_plus4=0x40 -> out_dest=31, out_link=1, out_pc_plus4=0x40. A write with wb_addr=0, wb_data=0xFF leaves r0 reading 0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable. Then flush=1 -> out_valid=0 next cycle, and no instruction was accepted.
- (SCOREBOARD_EN) Accept lw $4 (0x8C040000) then add $5,$4,$4 -> in_ready=0 until wb_en with wb_addr=4. In the wb cycle, in_ready=1 and out_rs_data=wb_data.
